// File: rtl/dcache_refill_ctrl_if.sv
// TileLink-UL A/D channel bundle between the data-cache sequencer (master) and the bus (slave).
interface dcache_refill_ctrl_if;
  logic        a_valid;
  logic        a_ready;
  logic [2:0]  a_opcode;
  logic [63:0] a_addr;
  logic [2:0]  a_size;
  logic [7:0]  a_mask;
  logic [63:0] a_data;
  logic        d_valid;
  logic        d_ready;
  logic [2:0]  d_opcode;
  logic        d_denied;
  logic [63:0] d_data;

  modport master (
    output a_valid, a_opcode, a_addr, a_size, a_mask, a_data, d_ready,
    input  a_ready, d_valid, d_opcode, d_denied, d_data
  );

  modport slave (
    input  a_valid, a_opcode, a_addr, a_size, a_mask, a_data, d_ready,
    output a_ready, d_valid, d_opcode, d_denied, d_data
  );
endinterface

// File: rtl/dcache_refill_ctrl.sv
// Load-miss refill / write-through store / fence sequencer for the direct-mapped data cache.
// Define DCACHE_TIMEOUT_EN to build a watchdog that aborts bus accesses after TIMEOUT_CYCLES.
module dcache_refill_ctrl #(
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  input  logic        req_load,
  input  logic [63:0] req_addr,
  input  logic [2:0]  req_size,
  input  logic [7:0]  req_mask,
  input  logic [63:0] req_wdata,
  output logic        stall,
  output logic        resp_valid,
  output logic        bus_err,
  input  logic        fence,
  input  logic        cache_hit,
  output logic [63:0] cache_addr,
  output logic        cache_invalid,
  output logic        cache_update,
  output logic [2:0]  cache_opcode,
  output logic [63:0] cache_update_data,
  dcache_refill_ctrl_if.master tl
);

  localparam logic [2:0] TL_GET      = 3'd4;
  localparam logic [2:0] TL_PUT_FULL = 3'd0;
  localparam logic [2:0] TL_ACK      = 3'd0;
  localparam logic [2:0] TL_ACK_DATA = 3'd1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    A_REQ  = 2'd1,
    D_WAIT = 2'd2,
    DONE   = 2'd3
  } state_t;

  state_t      state_reg;
  logic        load_reg;
  logic        err_reg;
  logic        fence_pend_reg;
  logic [63:0] addr_reg;
  logic [63:0] data_reg;
  logic [1:0]  size_reg;
  logic [7:0]  mask_reg;
  logic [2:0]  opcode_reg;

  logic        in_idle;
  logic        fence_now;
  logic        timeout_hit;
  logic [7:0]  size_mask;
  logic [7:0]  get_mask;

  // Bit 2 of req_size is the load zero-extend flag, consumed by the cache, not the bus.
  logic size_unused;
  assign size_unused = req_size[2];

  assign in_idle   = (state_reg == IDLE);
  assign fence_now = in_idle && (fence || fence_pend_reg);

  // Get needs a byte mask covering the naturally aligned access.
  always_comb begin
    case (req_size[1:0])
      2'd0:    size_mask = 8'h01;
      2'd1:    size_mask = 8'h03;
      2'd2:    size_mask = 8'h0F;
      default: size_mask = 8'hFF;
    endcase
    get_mask = size_mask << req_addr[2:0];
  end

`ifdef DCACHE_TIMEOUT_EN
  logic [15:0] timer_reg;
  assign timeout_hit = ((state_reg == A_REQ) || (state_reg == D_WAIT)) &&
                       ({16'd0, timer_reg} >= (TIMEOUT_CYCLES - 32'd1));
`else
  logic [31:0] timeout_cycles_unused;
  assign timeout_cycles_unused = TIMEOUT_CYCLES;
  assign timeout_hit = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg      <= IDLE;
      load_reg       <= 1'b0;
      err_reg        <= 1'b0;
      fence_pend_reg <= 1'b0;
      addr_reg       <= '0;
      data_reg       <= '0;
      size_reg       <= '0;
      mask_reg       <= '0;
      opcode_reg     <= '0;
`ifdef DCACHE_TIMEOUT_EN
      timer_reg      <= '0;
`endif
    end else begin
      if (!in_idle && fence) begin
        fence_pend_reg <= 1'b1;
      end
`ifdef DCACHE_TIMEOUT_EN
      if ((state_reg == A_REQ) || (state_reg == D_WAIT)) begin
        timer_reg <= timer_reg + 16'd1;
      end
`endif
      case (state_reg)
        IDLE: begin
          if (fence_now) begin
            fence_pend_reg <= 1'b0;
          end else if (req_valid && !(req_load && cache_hit)) begin
            state_reg  <= A_REQ;
            load_reg   <= req_load;
            err_reg    <= 1'b0;
            addr_reg   <= req_addr;
            size_reg   <= req_size[1:0];
            opcode_reg <= req_load ? TL_GET : TL_PUT_FULL;
            mask_reg   <= req_load ? get_mask : req_mask;
            data_reg   <= req_load ? 64'd0 : req_wdata;
`ifdef DCACHE_TIMEOUT_EN
            timer_reg  <= '0;
`endif
          end
        end
        A_REQ: begin
          if (timeout_hit) begin
            err_reg   <= 1'b1;
            state_reg <= DONE;
          end else if (tl.a_ready) begin
            state_reg <= D_WAIT;
          end
        end
        D_WAIT: begin
          // A response arriving on the deadline cycle still wins over the watchdog.
          if (tl.d_valid) begin
            err_reg   <= tl.d_denied | (load_reg & (tl.d_opcode != TL_ACK_DATA));
            state_reg <= DONE;
          end else if (timeout_hit) begin
            err_reg   <= 1'b1;
            state_reg <= DONE;
          end
        end
        DONE: begin
          state_reg <= IDLE;
        end
        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

  always_comb begin
    stall             = 1'b0;
    resp_valid        = 1'b0;
    bus_err           = 1'b0;
    cache_invalid     = 1'b0;
    cache_update      = 1'b0;
    cache_opcode      = TL_ACK;
    cache_update_data = '0;
    cache_addr        = '0;
    if (rst_n) begin
      cache_addr = addr_reg;
      case (state_reg)
        IDLE: begin
          cache_addr = req_addr;
          if (fence_now) begin
            cache_invalid = 1'b1;
            stall         = req_valid;
          end else if (req_valid) begin
            if (req_load && cache_hit) begin
              resp_valid = 1'b1;
            end else if (req_load) begin
              stall = 1'b1;
            end else begin
              stall        = 1'b1;
              cache_update = 1'b1;
            end
          end
        end
        A_REQ: begin
          stall        = 1'b1;
          cache_update = timeout_hit && load_reg;
        end
        D_WAIT: begin
          stall = 1'b1;
          if (tl.d_valid) begin
            if (load_reg) begin
              cache_update      = 1'b1;
              cache_opcode      = tl.d_denied ? TL_ACK : tl.d_opcode;
              cache_update_data = tl.d_data;
            end
          end else begin
            cache_update = timeout_hit && load_reg;
          end
        end
        default: begin
          resp_valid = 1'b1;
          bus_err    = err_reg;
        end
      endcase
    end
  end

  assign tl.a_valid  = rst_n && (state_reg == A_REQ);
  assign tl.d_ready  = rst_n && ((state_reg == IDLE) || (state_reg == D_WAIT));
  assign tl.a_opcode = opcode_reg;
  assign tl.a_addr   = addr_reg;
  assign tl.a_size   = {1'b0, size_reg};
  assign tl.a_mask   = mask_reg;
  assign tl.a_data   = data_reg;

endmodule

// File: doc/dcache_refill_ctrl.md
# dcache_refill_ctrl

Sequencer for the direct-mapped, write-through data cache. It sits between the memory stage, the cache, and the TileLink-UL master port. It detects load misses and issues a TL Get. It refills the line from the AccessAckData beat and replays the lookup. Stores are written through with PutFullData and invalidate the target line. Fence requests become whole-cache invalidation pulses.

## Interface
Parameters:
- TIMEOUT_CYCLES, 1024, watchdog limit in cycles; used only with DCACHE_TIMEOUT_EN.

Ports (reset rst_n, asynchronous, active-low; clock clk):
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  1  memory-stage op present
- req_load  in  1  1 = load, 0 = store
- req_addr  in  64  byte address
- req_size  in  3  log2 bytes; bit2 = zero-extend
- req_mask  in  8  store byte mask
- req_wdata  in  64  store data
- stall  out  1  pipeline must hold the request
- resp_valid  out  1  op complete; load data valid on cache data port
- bus_err  out  1  one-cycle pulse with resp_valid on denied or timed-out access
- fence  in  1  invalidate the whole cache
- cache_hit  in  1  cache hit for cache_addr
- cache_addr  out  64  lookup/update address: req_addr in IDLE, captured address otherwise
- cache_invalid  out  1  whole-cache invalidate pulse
- cache_update  out  1  line write strobe
- cache_opcode  out  3  TL D opcode forwarded to the cache; non-AckData invalidates the line
- cache_update_data  out  64  refill data
- a_valid  out  1, a_ready  in  1  TL A handshake
- a_opcode  out  3  Get = 4, PutFullData = 0
- a_addr  out  64, a_size  out  3, a_mask  out  8, a_data  out  64  TL A fields
- d_valid  in  1, d_ready  out  1  TL D handshake
- d_opcode  in  3, d_denied  in  1, d_data  in  64  TL D fields

## Operation
- States: IDLE, A_REQ, D_WAIT, DONE (2-bit encoding).
- In IDLE, outcomes are decided in priority order:
  - fence (or a pending fence): cache_invalid = 1 for one cycle, pending flag cleared, stall = req_valid that cycle.
  - load hit (req_valid & req_load & cache_hit): resp_valid = 1 combinationally; state stays IDLE.
  - load miss: capture addr/size; stall = 1; go to A_REQ with a_opcode = Get.
  - store: capture addr/size/mask/wdata; cache_update = 1 with cache_opcode = AccessAck (0), which invalidates the line; stall = 1; go to A_REQ with a_opcode = PutFullData.
- A_REQ: a_valid = 1; A fields are driven from captured registers and held stable until a_ready; a_valid & a_ready -> D_WAIT.
- D_WAIT: d_ready = 1. On d_valid:
  - load: cache_update = 1, cache_opcode = d_opcode, or 0 if d_denied; cache_update_data = d_data.
  - store: no cache action.
  - both: err flag = d_denied | (load & d_opcode != AccessAckData); go to DONE.
- DONE: stall = 0, resp_valid = 1, bus_err = err flag; the cache lookup now returns the refilled line; next state IDLE.
- stall = 1 in A_REQ and D_WAIT.
- d_ready = 1 in IDLE so stray responses are drained and discarded.
- A fence arriving in a non-IDLE state sets a pending flag. The flag is serviced on the first IDLE cycle, before any new request.
- All outputs are 0 in reset; state = IDLE; pending fence and err cleared.
- Reset mid-transaction abandons it; a late D beat is discarded in IDLE.

## Timing
- Load hit: 0 added cycles.
- Load miss: stall from the request cycle.
  - With a_ready and d_valid each arriving the first cycle they are awaited, resp_valid is asserted 3 cycles after the request cycle.
- Store: same latency as a load miss.
- cache_update is a single-cycle pulse; the cache writes it at the next posedge.
- Fence in IDLE costs exactly 1 cycle.

## Configuration
- DCACHE_TIMEOUT_EN defined:
  - A 16-bit counter runs in A_REQ and D_WAIT and clears on entering A_REQ.
  - Reaching TIMEOUT_CYCLES forces DONE with err = 1.
  - For a load it also pulses cache_update with opcode 0.
  - A late D beat is drained in IDLE.
- Undefined: no counter is built; the controller waits indefinitely; bus_err is asserted only on a denied or bad-opcode response.

## Test plan
- Load hit at 0x1008 with cache_hit = 1 -> resp_valid in the same cycle, no A traffic, stall = 0.
- Load miss at 0x2010; a_ready immediate; d_valid next cycle with opcode 1, data 0xDEADBEEF -> a_opcode = 4, a_addr = 0x2010; cache_update pulse carrying 0xDEADBEEF; resp_valid 3 cycles after the request.
- Store to 0x3000 with mask 0x0F, data 0x55 -> invalidate pulse (opcode 0) in the request cycle; PutFullData with a_mask = 0x0F, a_data = 0x55; resp_valid after AccessAck.
- Fence asserted during D_WAIT -> cache_invalid pulses exactly once, in the first IDLE cycle after DONE; a request presented in that cycle is stalled for one cycle.
- Load miss with d_denied = 1 -> cache_update with opcode 0; resp_valid together with bus_err = 1.
- With DCACHE_TIMEOUT_EN and TIMEOUT_CYCLES = 8, a_ready held low -> DONE after 8 cycles with bus_err = 1; rst_n pulsed mid-D_WAIT returns all outputs to 0.
